// File: rtl/td4_prog_loader.sv
// rtl/td4_prog_loader.sv - UART program loader and 16x8 program store for the TD4 CPU
//
// Receives a 16-byte program over an 8N1 UART line, framed as
//   SYNC_BYTE, 16 data bytes, checksum (sum of data bytes mod 256),
// writes it into a 16x8 store and holds the CPU in reset until a load
// with a valid checksum has committed.
//
// Ports:
//   CLK       board clock, all state on rising edge
//   RST       asynchronous active-low reset
//   RX        UART receive line, idle high, asynchronous to CLK
//   rd_addr   CPU fetch address
//   rd_data   mem[rd_addr], combinational
//   cpu_rst_n active-low CPU reset, high only in RUN
//   loading   high while a load or checksum byte is pending
//   chk_err   high after a failed load until the next SYNC_BYTE
//   load_ok   one-cycle pulse when a load commits
module td4_prog_loader #(
  parameter int          CLK_HZ    = 50000000,
  parameter int          BAUD      = 115200,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       cpu_rst_n,
  output logic       loading,
  output logic       chk_err,
  output logic       load_ok
);

  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int TW   = $clog2(DIV) + 1;

  localparam logic [TW-1:0] FULL_M1 = TW'(DIV - 1);
  localparam logic [TW-1:0] HALF_M1 = TW'(HALF - 1);

  // ---------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  rx_state_t      r_state;
  logic           rx_s1, rx_s2, rx_d;
  logic [TW-1:0]  timer;
  logic [2:0]     bit_cnt;
  logic [7:0]     shreg;
  logic           byte_valid;
  logic           frame_err;
  logic [7:0]     rx_byte;

  // A start is only recognised on a 1->0 transition of the synced line, so
  // a stop bit held low (frame error) cannot immediately retrigger a frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= R_IDLE;
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_d       <= 1'b1;
      timer      <= '0;
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      rx_byte    <= 8'h00;
    end else begin
      rx_s1      <= RX;
      rx_s2      <= rx_s1;
      rx_d       <= rx_s2;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (r_state)
        R_IDLE: begin
          if (rx_d && !rx_s2) begin
            r_state <= R_START;
            timer   <= '0;
          end
        end
        R_START: begin
          // Mid-bit sample: a pulse shorter than half a bit is a false start.
          if (timer == HALF_M1) begin
            timer   <= '0;
            bit_cnt <= 3'd0;
            r_state <= rx_s2 ? R_IDLE : R_DATA;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        R_DATA: begin
          if (timer == FULL_M1) begin
            timer   <= '0;
            shreg   <= {rx_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) r_state <= R_STOP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        R_STOP: begin
          if (timer == FULL_M1) begin
            timer   <= '0;
            r_state <= R_IDLE;
            if (rx_s2) begin
              byte_valid <= 1'b1;
              rx_byte    <= shreg;
            end else begin
              frame_err  <= 1'b1;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Loader FSM and program store
  // ---------------------------------------------------------------
  typedef enum logic [1:0] {RUN, LOAD, CHECK, ERR} ld_state_t;

  ld_state_t  state;
  logic [3:0] idx;
  logic [7:0] sum;
  logic [7:0] mem [16];

  assign rd_data = mem[rd_addr];

  // Outputs are assigned together with each state transition so they
  // change on the same edge as the state. RUN re-asserts its outputs every
  // cycle, which also releases cpu_rst_n on the first edge after reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= RUN;
      idx       <= 4'd0;
      sum       <= 8'h00;
      cpu_rst_n <= 1'b0;
      loading   <= 1'b0;
      chk_err   <= 1'b0;
      load_ok   <= 1'b0;
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
    end else begin
      load_ok <= 1'b0;
      case (state)
        RUN: begin
          cpu_rst_n <= 1'b1;
          loading   <= 1'b0;
          chk_err   <= 1'b0;
          if (byte_valid && rx_byte == SYNC_BYTE) begin
            state     <= LOAD;
            idx       <= 4'd0;
            sum       <= 8'h00;
            cpu_rst_n <= 1'b0;
            loading   <= 1'b1;
          end
        end
        LOAD: begin
          if (frame_err) begin
            state   <= ERR;
            loading <= 1'b0;
            chk_err <= 1'b1;
          end else if (byte_valid) begin
            // SYNC_BYTE is ordinary data here, never a restart.
            mem[idx] <= rx_byte;
            sum      <= sum + rx_byte;
            idx      <= idx + 4'd1;
            if (idx == 4'd15) state <= CHECK;
          end
        end
        CHECK: begin
          if (frame_err) begin
            state   <= ERR;
            loading <= 1'b0;
            chk_err <= 1'b1;
          end else if (byte_valid) begin
            loading <= 1'b0;
            if (rx_byte == sum) begin
              state     <= RUN;
              cpu_rst_n <= 1'b1;
              load_ok   <= 1'b1;
            end else begin
              state   <= ERR;
              chk_err <= 1'b1;
            end
          end
        end
        ERR: begin
          if (byte_valid && rx_byte == SYNC_BYTE) begin
            state   <= LOAD;
            idx     <= 4'd0;
            sum     <= 8'h00;
            loading <= 1'b1;
            chk_err <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_td4_prog_loader.sv
// tb/tb_td4_prog_loader.sv - self-checking bench for td4_prog_loader
module tb_td4_prog_loader;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         BITC = 16;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       cpu_rst_n, loading, chk_err, load_ok;

  int vectors     = 0;
  int miscompares = 0;
  int ok_seen     = 0;

  // Expected store contents, maintained at session level by each test.
  logic [7:0] m_mem [16];
  logic [7:0] pkt   [16];

  td4_prog_loader #(.CLK_HZ(16), .BAUD(1), .SYNC_BYTE(SYNC)) dut (
    .CLK(CLK), .RST(RST), .RX(RX), .rd_addr(rd_addr), .rd_data(rd_data),
    .cpu_rst_n(cpu_rst_n), .loading(loading), .chk_err(chk_err), .load_ok(load_ok)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (load_ok === 1'b1) ok_seen++;

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge CLK);
    RX = 1'b0;
    repeat (BITC) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BITC) @(negedge CLK);
    end
    RX = stop;
    repeat (BITC) @(negedge CLK);
    RX = 1'b1;
    repeat (6) @(negedge CLK);
  endtask

  function automatic logic [7:0] pkt_sum();
    logic [7:0] s = 8'h00;
    for (int i = 0; i < 16; i++) s = s + pkt[i];
    return s;
  endfunction

  task automatic send_session(input logic [7:0] chk);
    send_frame(SYNC, 1'b1);
    for (int i = 0; i < 16; i++) send_frame(pkt[i], 1'b1);
    send_frame(chk, 1'b1);
  endtask

  task automatic test_reset();
    RST = 1'b0; RX = 1'b1; rd_addr = 4'd0;
    repeat (3) @(negedge CLK);
    vectors++; if (cpu_rst_n !== 1'b0) begin miscompares++; $display("FAIL reset_cpu_rst_n got %b want 0", cpu_rst_n); end
    vectors++; if ({loading, chk_err, load_ok} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got %b want 000", {loading, chk_err, load_ok}); end
    RST = 1'b1;
    #1;
    vectors++; if (cpu_rst_n !== 1'b0) begin miscompares++; $display("FAIL release_pre_edge got %b want 0", cpu_rst_n); end
    @(negedge CLK);
    vectors++; if (cpu_rst_n !== 1'b1) begin miscompares++; $display("FAIL release_post_edge got %b want 1", cpu_rst_n); end
    for (int a = 0; a < 16; a++) begin
      m_mem[a] = 8'h00;
      rd_addr = 4'(a); #1;
      vectors++; if (rd_data !== 8'h00) begin miscompares++; $display("FAIL reset_mem[%0d] got %h want 00", a, rd_data); end
    end
  endtask

  task automatic test_good_load();
    int ok0 = ok_seen;
    for (int i = 0; i < 16; i++) pkt[i] = 8'(i);
    send_frame(SYNC, 1'b1);
    vectors++; if (cpu_rst_n !== 1'b0 || loading !== 1'b1) begin miscompares++; $display("FAIL good_after_sync got rst_n=%b loading=%b want 0 1", cpu_rst_n, loading); end
    for (int i = 0; i < 16; i++) send_frame(pkt[i], 1'b1);
    vectors++; if (loading !== 1'b1 || ok_seen != ok0) begin miscompares++; $display("FAIL good_before_chk got loading=%b ok=%0d want 1 %0d", loading, ok_seen - ok0, 0); end
    send_frame(8'h78, 1'b1);
    for (int i = 0; i < 16; i++) m_mem[i] = pkt[i];
    vectors++; if (ok_seen != ok0 + 1) begin miscompares++; $display("FAIL good_load_ok got %0d pulses want 1", ok_seen - ok0); end
    vectors++; if ({cpu_rst_n, loading, chk_err} !== 3'b100) begin miscompares++; $display("FAIL good_flags got %b want 100", {cpu_rst_n, loading, chk_err}); end
    rd_addr = 4'd5; #1;
    vectors++; if (rd_data !== 8'h05) begin miscompares++; $display("FAIL good_mem5 got %h want 05", rd_data); end
  endtask

  task automatic test_bad_checksum();
    int ok0 = ok_seen;
    send_session(8'h77);
    vectors++; if ({cpu_rst_n, loading, chk_err} !== 3'b001) begin miscompares++; $display("FAIL bad_flags got %b want 001", {cpu_rst_n, loading, chk_err}); end
    vectors++; if (ok_seen != ok0) begin miscompares++; $display("FAIL bad_no_ok got %0d pulses want 0", ok_seen - ok0); end
    for (int i = 0; i < 16; i++) pkt[i] = 8'($urandom);
    send_session(pkt_sum());
    for (int i = 0; i < 16; i++) m_mem[i] = pkt[i];
    vectors++; if ({cpu_rst_n, loading, chk_err} !== 3'b100) begin miscompares++; $display("FAIL recover_flags got %b want 100", {cpu_rst_n, loading, chk_err}); end
    vectors++; if (ok_seen != ok0 + 1) begin miscompares++; $display("FAIL recover_ok got %0d pulses want 1", ok_seen - ok0); end
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a); #1;
      vectors++; if (rd_data !== m_mem[a]) begin miscompares++; $display("FAIL recover_mem[%0d] got %h want %h", a, rd_data, m_mem[a]); end
    end
  endtask

  task automatic test_glitch();
    send_frame(8'h3C, 1'b1);
    @(negedge CLK);
    RX = 1'b0;
    repeat (8) @(negedge CLK);
    RX = 1'b1;
    repeat (40) @(negedge CLK);
    vectors++; if ({cpu_rst_n, loading, chk_err} !== 3'b100) begin miscompares++; $display("FAIL glitch_flags got %b want 100", {cpu_rst_n, loading, chk_err}); end
    // A receiver fooled by the glitch would misalign on this sync byte.
    send_frame(SYNC, 1'b1);
    vectors++; if (loading !== 1'b1) begin miscompares++; $display("FAIL glitch_then_sync got loading=%b want 1", loading); end
  endtask

  task automatic test_frame_err();
    // Enters from LOAD (left by test_glitch); start a fresh session via an error first.
    send_frame(8'h00, 1'b0);
    send_frame(SYNC, 1'b1);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b = 8'($urandom);
      m_mem[i] = b;
      send_frame(b, 1'b1);
    end
    send_frame(8'h5A, 1'b0);
    vectors++; if ({cpu_rst_n, loading, chk_err} !== 3'b001) begin miscompares++; $display("FAIL ferr_flags got %b want 001", {cpu_rst_n, loading, chk_err}); end
    send_frame(8'h55, 1'b1);
    vectors++; if ({cpu_rst_n, loading, chk_err} !== 3'b001) begin miscompares++; $display("FAIL ferr_ignore55 got %b want 001", {cpu_rst_n, loading, chk_err}); end
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a); #1;
      vectors++; if (rd_data !== m_mem[a]) begin miscompares++; $display("FAIL ferr_mem[%0d] got %h want %h", a, rd_data, m_mem[a]); end
    end
  endtask

  task automatic test_reset_mid_load();
    send_frame(SYNC, 1'b1);
    for (int i = 0; i < 8; i++) send_frame(8'($urandom), 1'b1);
    vectors++; if (loading !== 1'b1) begin miscompares++; $display("FAIL midload_loading got %b want 1", loading); end
    RST = 1'b0; #1;
    vectors++; if ({cpu_rst_n, loading, chk_err, load_ok} !== 4'b0000) begin miscompares++; $display("FAIL midload_rst_flags got %b want 0000", {cpu_rst_n, loading, chk_err, load_ok}); end
    for (int a = 0; a < 16; a++) begin
      m_mem[a] = 8'h00;
      rd_addr = 4'(a); #1;
      vectors++; if (rd_data !== 8'h00) begin miscompares++; $display("FAIL midload_mem[%0d] got %h want 00", a, rd_data); end
    end
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    vectors++; if ({cpu_rst_n, loading, chk_err} !== 3'b100) begin miscompares++; $display("FAIL midload_release got %b want 100", {cpu_rst_n, loading, chk_err}); end
  endtask

  task automatic test_random_sessions();
    for (int s = 0; s < 4; s++) begin
      int       ok0 = ok_seen;
      bit       bad = 1'($urandom);
      logic [7:0] chk;
      logic [7:0] junk = 8'($urandom);
      if (junk == SYNC) junk = 8'h5A;
      send_frame(junk, 1'b1);
      for (int i = 0; i < 16; i++) pkt[i] = 8'($urandom);
      pkt[$urandom_range(0, 15)] = SYNC;
      chk = pkt_sum();
      if (bad) chk = chk + 8'($urandom_range(1, 255));
      send_session(chk);
      for (int i = 0; i < 16; i++) m_mem[i] = pkt[i];
      vectors++;
      if ({cpu_rst_n, loading, chk_err} !== (bad ? 3'b001 : 3'b100)) begin
        miscompares++; $display("FAIL rand%0d_flags got %b want %b", s, {cpu_rst_n, loading, chk_err}, bad ? 3'b001 : 3'b100);
      end
      vectors++;
      if (ok_seen != ok0 + (bad ? 0 : 1)) begin
        miscompares++; $display("FAIL rand%0d_ok got %0d want %0d", s, ok_seen - ok0, bad ? 0 : 1);
      end
      for (int a = 0; a < 16; a++) begin
        rd_addr = 4'(a); #1;
        vectors++; if (rd_data !== m_mem[a]) begin miscompares++; $display("FAIL rand%0d_mem[%0d] got %h want %h", s, a, rd_data, m_mem[a]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_glitch();
    test_frame_err();
    test_reset_mid_load();
    test_random_sessions();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/td4_prog_loader.md
Name: td4_prog_loader

Overview:
- Writer-side counterpart of the TD4 instruction ROM: receives a 16-byte program over an 8N1 UART line and writes it into a 16x8 program store.
- The CPU fetches from this store through a combinational read port.
- Holds the CPU in reset while a load is in progress or after a failed load; releases it only after a load whose checksum is valid.
- Sits beside cpu.v on the board clock CLK, replacing the fixed ROM contents.

Parameters:
CLK_HZ, 50000000, board clock frequency in Hz
BAUD, 115200, UART bit rate; DIV = CLK_HZ/BAUD clocks per bit (integer division, DIV >= 4 required)
SYNC_BYTE, 8'hA5, byte that starts a load session

Ports:
CLK  in  1  board clock; all state on rising edge
RST  in  1  asynchronous, active-low reset
RX  in  1  UART receive line, idle high, asynchronous to CLK
rd_addr  in  4  CPU fetch address
rd_data  out  8  mem[rd_addr], combinational
cpu_rst_n  out  1  active-low reset to CPU; low while state != RUN
loading  out  1  high in LOAD and CHECK
chk_err  out  1  high in ERR state
load_ok  out  1  one-cycle pulse when a load commits

Behaviour:
- Reset (RST low, async): mem[0..15]=8'h00, state=RUN, cpu_rst_n=0, loading=0, chk_err=0, load_ok=0, byte index=0, sum=0, UART receiver idle. cpu_rst_n goes to 1 on the first CLK edge after RST is released.
- RX path: 2-flop synchronizer; all logic uses the synced value.
- Receiver FSM, states R_IDLE, R_START, R_DATA, R_STOP.
  - R_IDLE: synced RX falling to 0 -> R_START, bit timer=0.
  - R_START: at DIV/2 clocks, sample. 1 = false start -> R_IDLE; 0 -> R_DATA.
  - R_DATA: sample every DIV clocks, 8 bits LSB first.
  - R_STOP: sample after DIV clocks. 1 -> byte_valid pulse for 1 cycle with the byte; 0 -> frame_err pulse, byte discarded. Either way -> R_IDLE.
- Loader FSM, states RUN, LOAD, CHECK, ERR.
  - RUN: byte==SYNC_BYTE -> LOAD, index=0, sum=0. Other bytes and frame errors are ignored.
  - LOAD: each valid byte is written to mem[index]; sum += byte (mod 256); index++. After index 15 is written -> CHECK.
  - CHECK: next valid byte == sum -> RUN, load_ok=1 for one cycle. Mismatch -> ERR.
  - ERR: only SYNC_BYTE leaves, -> LOAD with index=0, sum=0. Other bytes are ignored.
  - Frame error in LOAD or CHECK -> ERR.
  - SYNC_BYTE received in LOAD or CHECK is treated as data or checksum, not as a restart.
- Outputs are registered from state: cpu_rst_n=(state==RUN), loading=(LOAD|CHECK), chk_err=(ERR). They update on the same edge as the state change.
- Memory is written only in LOAD. A failed load leaves the partially written contents, but the CPU stays held.
- Reset mid-load: everything returns to reset values and the store is cleared.
- byte_valid and frame_err never occur in the same cycle.

Test Plan:
(All scenarios use CLK_HZ=16, BAUD=1, so DIV=16.)
1. Reset then idle RX=1 -> cpu_rst_n=0 during reset, 1 one cycle after RST release; rd_data=8'h00 for all addresses.
2. Send A5, 00..0F, checksum 78 -> cpu_rst_n goes 0 after the A5 stop bit; loading=1; load_ok pulses once after 78; rd_addr=5 gives rd_data=8'h05; cpu_rst_n=1.
3. Same sequence with checksum 77 -> chk_err=1, cpu_rst_n stays 0. Then send a correct A5 session -> chk_err=0, load_ok pulses.
4. In RUN send 3C, then an 8-clock low glitch on RX -> no state change; glitch rejected at the start sample.
5. In LOAD after 4 bytes, send a frame with stop bit 0 -> ERR; a following byte 55 is ignored; mem[0..3] hold the sent data.
6. Assert RST after 8 loaded bytes -> all outputs at reset values, mem cleared, RUN state after release.
